// File: rtl/gray_binary_conv_arbiter.sv
// Round-robin arbiter sharing one bit-serial Gray-to-binary engine among NREQ requesters.
// The engine resolves one bit per clock, MSB first, then pulses done to the granted requester.
module gray_binary_conv_arbiter #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 4,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] gray_in,
    output logic [NREQ-1:0]       grant,
    output logic [WIDTH-1:0]      bin_out,
    output logic [NREQ-1:0]       done,
    output logic                  busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t            state_reg, state_next;
    logic [PW-1:0]     ptr_reg, ptr_next;
    logic [PW-1:0]     sel_reg, sel_next;
    logic [NREQ-1:0]   grant_reg, grant_next;
    logic [NREQ-1:0]   done_reg, done_next;
    logic [WIDTH-1:0]  g_reg, g_next;
    logic [WIDTH-1:0]  b_reg, b_next;
    logic [WIDTH-1:0]  bin_reg, bin_next;
    logic [CW-1:0]     idx_reg, idx_next;

    logic [WIDTH-1:0]  gray_arr [NREQ];
    logic [WIDTH-1:0]  bit_val;
    logic [WIDTH-1:0]  b_work;
    logic [NREQ-1:0]   req_rot;
    logic [PW-1:0]     rr_off;
    logic [PW:0]       sel_sum;
    logic [PW-1:0]     sel_idx;
    logic [NREQ-1:0]   sel_onehot;
    logic [WIDTH-1:0]  gray_sel;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign gray_arr[gi] = gray_in[gi*WIDTH +: WIDTH];
        end
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            if (gi == WIDTH - 1) begin : g_msb
                assign bit_val[gi] = g_reg[gi];
            end else begin : g_lower
                assign bit_val[gi] = b_reg[gi+1] ^ g_reg[gi];
            end
        end
    endgenerate

    // Rotate requests so the pointer sits at bit 0; the lowest set bit is then the winner.
    assign req_rot = NREQ'({req, req} >> ptr_reg);

    always_comb begin
        rr_off = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_rot[i]) rr_off = PW'(i);
        end
        sel_sum = {1'b0, ptr_reg} + {1'b0, rr_off};
        if (sel_sum >= (PW+1)'(NREQ)) sel_idx = PW'(sel_sum - (PW+1)'(NREQ));
        else                          sel_idx = sel_sum[PW-1:0];
        sel_onehot = NREQ'(1) << sel_idx;
    end

    always_comb begin
        gray_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (sel_onehot[i]) gray_sel = gray_sel | gray_arr[i];
        end
    end

    // Only the bit addressed by idx is resolved this cycle; the rest of b_reg holds.
    always_comb begin
        b_work = b_reg;
        for (int i = 0; i < WIDTH; i++) begin
            if (idx_reg == CW'(i)) b_work[i] = bit_val[i];
        end
    end

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        sel_next   = sel_reg;
        grant_next = grant_reg;
        done_next  = done_reg;
        g_next     = g_reg;
        b_next     = b_reg;
        bin_next   = bin_reg;
        idx_next   = idx_reg;
        case (state_reg)
            IDLE: begin
                if (|req) begin
                    g_next     = gray_sel;
                    b_next     = '0;
                    sel_next   = sel_idx;
                    grant_next = sel_onehot;
                    idx_next   = CW'(WIDTH - 1);
                    state_next = CONV;
                end
            end
            CONV: begin
                b_next   = b_work;
                idx_next = idx_reg - CW'(1);
                if (idx_reg == '0) begin
                    bin_next   = b_work;
                    done_next  = grant_reg;
                    state_next = DONE;
                end
            end
            DONE: begin
                grant_next = '0;
                done_next  = '0;
                ptr_next   = (sel_reg == PW'(NREQ - 1)) ? '0 : sel_reg + PW'(1);
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
            sel_reg   <= '0;
            grant_reg <= '0;
            done_reg  <= '0;
            g_reg     <= '0;
            b_reg     <= '0;
            bin_reg   <= '0;
            idx_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            sel_reg   <= sel_next;
            grant_reg <= grant_next;
            done_reg  <= done_next;
            g_reg     <= g_next;
            b_reg     <= b_next;
            bin_reg   <= bin_next;
            idx_reg   <= idx_next;
        end
    end

    assign grant   = grant_reg;
    assign done    = done_reg;
    assign bin_out = bin_reg;
    assign busy    = (state_reg != IDLE);

endmodule

// File: tb/tb_gray_binary_conv_arbiter.sv
// Randomized and directed bench for gray_binary_conv_arbiter against a cycle-count reference model.
module tb_gray_binary_conv_arbiter;

    localparam int W  = 4;
    localparam int NR = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NR-1:0]   req = '0;
    logic [W-1:0]    words [NR];
    logic [NR*W-1:0] gray_bus;
    logic [NR-1:0]   grant;
    logic [W-1:0]    bin_out;
    logic [NR-1:0]   done;
    logic            busy;

    gray_binary_conv_arbiter #(.WIDTH(W), .NREQ(NR)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .gray_in (gray_bus),
        .grant   (grant),
        .bin_out (bin_out),
        .done    (done),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        gray_bus = '0;
        for (int i = 0; i < NR; i++) gray_bus[i*W +: W] = words[i];
    end

    int n_checks = 0;
    int n_errors = 0;
    int cycle    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d: got=%0h expected=%0h", tag, cycle, got, exp);
        end
    endtask

    // Reference model: phase 0 idle, 1..W converting, W+1 the done cycle.
    int           phase = 0;
    int           m_k   = 0;
    int           m_ptr = 0;
    logic [W-1:0] m_word = '0;
    logic [W-1:0] m_bin  = '0;

    function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
        logic [W-1:0] b;
        b = g;
        for (int s = 1; s < W; s++) b = b ^ (g >> s);
        return b;
    endfunction

    task automatic check_outputs();
        logic [NR-1:0] eg;
        logic [NR-1:0] ed;
        eg = (phase != 0)     ? (NR'(1) << m_k) : '0;
        ed = (phase == W + 1) ? (NR'(1) << m_k) : '0;
        check("grant",   32'(grant),   32'(eg));
        check("done",    32'(done),    32'(ed));
        check("bin_out", 32'(bin_out), 32'(m_bin));
        check("busy",    32'(busy),    32'(phase != 0));
    endtask

    task automatic step();
        bit found;
        @(posedge clk);
        cycle++;
        if (phase == 0) begin
            if (req != '0) begin
                found = 1'b0;
                for (int off = 0; off < NR; off++) begin
                    if (!found && req[(m_ptr + off) % NR]) begin
                        m_k   = (m_ptr + off) % NR;
                        found = 1'b1;
                    end
                end
                m_word = words[m_k];
                phase  = 1;
            end
        end else if (phase == W + 1) begin
            phase = 0;
            m_ptr = (m_k + 1) % NR;
        end else begin
            phase++;
            if (phase == W + 1) begin
                m_bin = g2b(m_word);
                $display("xfer cyc=%0d req=%0d gray=%b bin=%b", cycle, m_k, m_word, m_bin);
            end
        end
        #1;
        check_outputs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic convert(input int k, input logic [W-1:0] word);
        words[k] = word;
        req      = NR'(1) << k;
        step();
        req = '0;
        run(W + 1);
    endtask

    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        phase = 0;
        m_ptr = 0;
        m_bin = '0;
        $display("abort cyc=%0d", cycle);
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < NR; i++) words[i] = '0;
        @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        run(2);

        convert(0, 4'b0110);
        convert(0, 4'b1111);
        convert(0, 4'b1000);

        for (int g = 0; g < 16; g++) convert(0, W'(g));

        words[0] = 4'b0001; words[1] = 4'b0011; words[2] = 4'b0010; words[3] = 4'b0110;
        req = 4'b1111;
        run(5 * (W + 2));
        req = '0;
        run(W + 2);

        req = 4'b0101;
        run(3 * (W + 2));
        req = '0;
        run(W + 2);

        // Abort: finish on requester 1 so the pointer moves, then kill a conversion after E2.
        convert(1, 4'b1010);
        words[3] = 4'b1101;
        req = 4'b1000;
        run(3);
        req = '0;
        async_reset();
        req = 4'b0110;
        step();
        req = '0;
        run(W + 2);

        // Drop req and change the word right after capture.
        words[1] = 4'b0111;
        req = 4'b0010;
        step();
        req = '0;
        words[1] = 4'b1000;
        run(W + 4);

        for (int i = 0; i < 400; i++) begin
            req = NR'($urandom_range(0, (1 << NR) - 1));
            for (int j = 0; j < NR; j++) words[j] = W'($urandom_range(0, (1 << W) - 1));
            step();
        end
        req = '0;
        run(W + 2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/gray_binary_conv_arbiter.md
Name: gray_binary_conv_arbiter

Overview:
- Shares one bit-serial Gray-to-binary conversion engine among NREQ requesters.
- Each requester presents a WIDTH-bit Gray word and holds req high.
- A round-robin arbiter grants one requester and captures its word.
- The engine resolves the word MSB-first, one bit per clock, then returns the binary result with a one-cycle done pulse to the granted requester.

Parameters:
- WIDTH, 4, Gray/binary word width in bits (>=2).
- NREQ, 4, number of requesters (>=2).
- CW, $clog2(WIDTH), width of the bit-index counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req  input  NREQ  per-requester request, level-held.
- gray_in  input  NREQ*WIDTH  packed Gray words; requester k occupies [k*WIDTH +: WIDTH].
- grant  output  NREQ  one-hot; high from capture until done completes.
- bin_out  output  WIDTH  binary result of the most recent completed conversion.
- done  output  NREQ  one-hot, one-cycle pulse to the granted requester when bin_out is valid.
- busy  output  1  high whenever state != IDLE.

Behaviour:
Reset (async, rst_n=0):
- state=IDLE; grant=0, done=0, bin_out=0, busy=0.
- Internal shift/work registers cleared.
- RR pointer set so requester 0 has highest priority.
- Takes effect immediately, including mid-conversion. The in-flight conversion is abandoned with no done pulse.

States: IDLE, CONV, DONE.

IDLE:
- On a clock edge with req!=0, select the first asserted req searching from ptr upward with wrap (ptr = last granted index + 1 mod NREQ).
- Capture that requester's Gray word into g_reg.
- Set grant[k]=1 and idx=WIDTH-1, then go to CONV.
- With req==0, stay in IDLE.

CONV:
- Each edge computes one bit and decrements idx:
  - b_reg[WIDTH-1] = g_reg[WIDTH-1].
  - b_reg[i] = b_reg[i+1] ^ g_reg[i] for i < WIDTH-1.
- When idx==0 is processed, go to DONE. CONV therefore lasts exactly WIDTH cycles.

DONE:
- For one cycle: bin_out=b_reg (registered update on the CONV->DONE edge), done[k]=1, grant[k] still 1.
- Next edge: grant=0, done=0, ptr=k+1 mod NREQ, go to IDLE.

Latency:
- Capture edge E0; done high in the cycle following edge E_WIDTH.
- A new grant is issued no earlier than edge E_(WIDTH+2). Minimum period per conversion is WIDTH+2 cycles.

Holds and request handling:
- bin_out changes only on the CONV->DONE edge and holds between conversions. Partial results are never visible.
- req and gray_in are ignored outside IDLE. A requester dropping req mid-conversion does not abort; done still pulses.
- A requester keeping req high after done is re-arbitrated in IDLE under round-robin, so it cannot starve others.
- Multiple simultaneous reqs in IDLE: exactly one grant; the others wait.
- gray_in may change after capture without affecting the result.

Invariants:
- grant and done are always one-hot-or-zero.
- done is a subset of grant.
- busy = (grant != 0).

Test Plan:
1. Basic conversion: req=0001, gray_in[3:0]=0110 -> grant=0001 after E0; done=0001 for one cycle after E4 with bin_out=0100; grant=0 after E5. Repeat with 1111 -> 1010 and 1000 -> 1111.
2. Exhaustive: requester 0 drives all 16 Gray codes sequentially -> each bin_out equals the XOR-prefix reference (0000->0000, 0001->0001, 0011->0010, ..., 1000->1111). Exactly one done per request.
3. Round-robin: req=1111 held with distinct words (0001, 0011, 0010, 0110) -> grants in order 0001, 0010, 0100, 1000, 0001. Results 0001, 0010, 0011, 0100. Consecutive grants spaced 6 cycles apart.
4. Fairness: req=0101 held continuously -> grants alternate 0001, 0100, 0001. Requester 2 is never starved.
5. Abort: assert rst_n=0 asynchronously mid-CONV (after E2) -> grant, done, bin_out and busy go to 0 immediately, with no done pulse. After release, req=0010 is granted first only if req0 is idle (priority restarts at 0).
6. Request drop and late change: requester 1 drops req and changes gray_in after E0 -> conversion still completes on the captured word, done=0010 after E4; no re-grant follows.
